// File: rtl/max7219_rx.sv
// MAX7219 serial receiver: oversamples din/clk/ce_ pins, shadows the register
// file and decodes digit segment patterns back to hex nibbles.
module max7219_rx #(
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        max_din,
   input  logic        max_clk,
   input  logic        ce_,
   output logic [63:0] digits,
   output logic [7:0]  decode_mode,
   output logic [3:0]  intensity,
   output logic [2:0]  scan_limit,
   output logic        shutdown_n,
   output logic        display_test,
   output logic [31:0] hex_value,
   output logic [7:0]  hex_valid,
   output logic        frame_valid,
   output logic [3:0]  frame_addr,
   output logic [7:0]  frame_data,
   output logic        frame_err
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_LATCH = 2'd2;

   logic [SYNC_STAGES-1:0] din_sync, clk_sync, ce_sync;
   logic                   clk_hist, ce_hist;
   logic                   din_s, clk_s, ce_s;
   logic                   clk_rise, ce_rise, ce_fall;

   logic [1:0]             state;
   logic [15:0]            shift_reg;
   logic [4:0]             bit_cnt;
   logic [7:0][7:0]        digit_reg;
   logic [3:0]             unused_hi;

   // ce_ idles high, so its chain resets to 1 to avoid a false edge on release
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         din_sync <= '0;
         clk_sync <= '0;
         ce_sync  <= '1;
         clk_hist <= 1'b0;
         ce_hist  <= 1'b1;
      end else begin
         din_sync <= {din_sync[SYNC_STAGES-2:0], max_din};
         clk_sync <= {clk_sync[SYNC_STAGES-2:0], max_clk};
         ce_sync  <= {ce_sync[SYNC_STAGES-2:0], ce_};
         clk_hist <= clk_s;
         ce_hist  <= ce_s;
      end
   end

   assign din_s     = din_sync[SYNC_STAGES-1];
   assign clk_s     = clk_sync[SYNC_STAGES-1];
   assign ce_s      = ce_sync[SYNC_STAGES-1];
   assign clk_rise  = clk_s & ~clk_hist;
   assign ce_rise   = ce_s & ~ce_hist;
   assign ce_fall   = ~ce_s & ce_hist;
   assign unused_hi = shift_reg[15:12];

   // Register write and pulses happen on the ce_ rising edge itself so they
   // are visible the cycle after that edge; LATCH is a one-cycle guard state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         shift_reg    <= '0;
         bit_cnt      <= '0;
         digit_reg    <= '0;
         decode_mode  <= '0;
         intensity    <= '0;
         scan_limit   <= '0;
         shutdown_n   <= 1'b0;
         display_test <= 1'b0;
         frame_valid  <= 1'b0;
         frame_err    <= 1'b0;
         frame_addr   <= '0;
         frame_data   <= '0;
      end else begin
         frame_valid <= 1'b0;
         frame_err   <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (ce_fall) begin
                  state     <= ST_SHIFT;
                  shift_reg <= '0;
                  bit_cnt   <= '0;
               end
            end
            ST_SHIFT: begin
               if (ce_rise) begin
                  state <= ST_LATCH;
                  if (bit_cnt == 5'd16) begin
                     frame_valid <= 1'b1;
                     frame_addr  <= shift_reg[11:8];
                     frame_data  <= shift_reg[7:0];
                     case (shift_reg[11:8])
                        4'h9: decode_mode  <= shift_reg[7:0];
                        4'hA: intensity    <= shift_reg[3:0];
                        4'hB: scan_limit   <= shift_reg[2:0];
                        4'hC: shutdown_n   <= shift_reg[0];
                        4'hF: display_test <= shift_reg[0];
                        default: begin
                           for (int i = 0; i < 8; i++)
                              if (shift_reg[11:8] == 4'(i + 1))
                                 digit_reg[i] <= shift_reg[7:0];
                        end
                     endcase
                  end else begin
                     frame_err <= 1'b1;
                  end
               end else if (clk_rise) begin
                  shift_reg <= {shift_reg[14:0], din_s};
                  if (bit_cnt != 5'd31)
                     bit_cnt <= bit_cnt + 5'd1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign digits = digit_reg;

   // Segment pattern (a..g = bits 6..0) to {match, nibble}
   function automatic logic [4:0] glyph_dec(input logic [6:0] seg);
      case (seg)
         7'h7E: glyph_dec = 5'h10;
         7'h30: glyph_dec = 5'h11;
         7'h6D: glyph_dec = 5'h12;
         7'h79: glyph_dec = 5'h13;
         7'h33: glyph_dec = 5'h14;
         7'h5B: glyph_dec = 5'h15;
         7'h5F: glyph_dec = 5'h16;
         7'h70: glyph_dec = 5'h17;
         7'h7F: glyph_dec = 5'h18;
         7'h7B: glyph_dec = 5'h19;
         7'h77: glyph_dec = 5'h1A;
         7'h1F: glyph_dec = 5'h1B;
         7'h4E: glyph_dec = 5'h1C;
         7'h3D: glyph_dec = 5'h1D;
         7'h4F: glyph_dec = 5'h1E;
         7'h47: glyph_dec = 5'h1F;
         default: glyph_dec = 5'h00;
      endcase
   endfunction

   always_comb begin
      logic [4:0] dec;
      hex_value = '0;
      hex_valid = '0;
      for (int i = 0; i < 8; i++) begin
         dec = glyph_dec(digit_reg[i][6:0]);
         if (dec[4] && !decode_mode[i]) begin
            hex_valid[i]       = 1'b1;
            hex_value[4*i +: 4] = dec[3:0];
         end
      end
   end

endmodule

// File: tb/tb_max7219_rx.sv
// Randomized scoreboard bench for max7219_rx against a register-file model.
module tb_max7219_rx;

   logic        clk, rst_n, max_din, max_clk, ce_;
   logic [63:0] digits;
   logic [7:0]  decode_mode, hex_valid, frame_data;
   logic [3:0]  intensity, frame_addr;
   logic [2:0]  scan_limit;
   logic        shutdown_n, display_test, frame_valid, frame_err;
   logic [31:0] hex_value;

   max7219_rx #(.SYNC_STAGES(2)) dut (
      .clk(clk), .rst_n(rst_n), .max_din(max_din), .max_clk(max_clk), .ce_(ce_),
      .digits(digits), .decode_mode(decode_mode), .intensity(intensity),
      .scan_limit(scan_limit), .shutdown_n(shutdown_n), .display_test(display_test),
      .hex_value(hex_value), .hex_valid(hex_valid), .frame_valid(frame_valid),
      .frame_addr(frame_addr), .frame_data(frame_data), .frame_err(frame_err)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   typedef struct {
      logic [1:0] kind;   // 2'b10 = frame_valid, 2'b01 = frame_err
      logic [3:0] addr;
      logic [7:0] data;
      int         cyc;
   } exp_t;

   exp_t       sb[$];
   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   logic [7:0] regs [16];
   logic [3:0] last_addr;
   logic [7:0] last_data;
   logic [6:0] glyph [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                              7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every pulse must match the oldest expected frame outcome
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && (frame_valid || frame_err)) begin
         if (sb.size() == 0) begin
            chk("unexpected_pulse", {frame_valid, frame_err}, 2'b00);
         end else begin
            e = sb.pop_front();
            chk("pulse_kind", {frame_valid, frame_err}, e.kind);
            chk("pulse_cycle", cyc, e.cyc);
            chk("frame_addr", frame_addr, e.addr);
            chk("frame_data", frame_data, e.data);
         end
      end
   end

   task automatic model_reset();
      for (int a = 0; a < 16; a++) regs[a] = 8'h00;
      last_addr = 4'h0;
      last_data = 8'h00;
   endtask

   // A frame is accepted only with exactly 16 bits; the low 12 bits hold addr/data.
   task automatic model_frame(input logic [31:0] bits, input int n, input int ce_cyc);
      exp_t e;
      if (n == 16) begin
         last_addr = bits[11:8];
         last_data = bits[7:0];
         regs[last_addr] = last_data;
         e.kind = 2'b10;
      end else begin
         e.kind = 2'b01;
      end
      e.addr = last_addr;
      e.data = last_data;
      e.cyc  = ce_cyc + 3;
      sb.push_back(e);
   endtask

   task automatic check_regs();
      logic [63:0] ed;
      logic [31:0] ehv;
      logic [7:0]  evl;
      ed = '0; ehv = '0; evl = '0;
      for (int i = 0; i < 8; i++) begin
         ed[8*i +: 8] = regs[i+1];
         for (int v = 0; v < 16; v++)
            if (glyph[v] == regs[i+1][6:0] && !regs[9][i]) begin
               evl[i] = 1'b1;
               ehv[4*i +: 4] = 4'(v);
            end
      end
      chk("digits", digits, ed);
      chk("decode_mode", decode_mode, regs[9]);
      chk("intensity", intensity, regs[10][3:0]);
      chk("scan_limit", scan_limit, regs[11][2:0]);
      chk("shutdown_n", shutdown_n, regs[12][0]);
      chk("display_test", display_test, regs[15][0]);
      chk("hex_value", hex_value, ehv);
      chk("hex_valid", hex_valid, evl);
      chk("last_addr", frame_addr, last_addr);
      chk("last_data", frame_data, last_data);
   endtask

   // Shift n bits MSB first; collide adds a 17th max_clk rise coincident with ce_ rise
   task automatic send_frame(input logic [31:0] bits, input int n, input int hp, input bit collide);
      int ce_cyc;
      @(negedge clk) ce_ = 1'b0;
      repeat (hp) @(negedge clk);
      for (int i = n - 1; i >= 0; i--) begin
         max_din = bits[i];
         repeat (hp) @(negedge clk);
         max_clk = 1'b1;
         repeat (hp) @(negedge clk);
         max_clk = 1'b0;
      end
      if (collide) max_din = 1'($urandom);
      repeat (hp) @(negedge clk);
      ce_ = 1'b1;
      if (collide) max_clk = 1'b1;
      ce_cyc = cyc;
      model_frame(bits, n, ce_cyc);
      repeat (hp + 6) @(negedge clk);
      max_clk = 1'b0;
      repeat (hp + 2) @(negedge clk);
      check_regs();
   endtask

   initial begin
      #4ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] hx;
      logic [31:0] bits;
      logic [3:0]  a;
      int          n;
      rst_n = 1'b0; max_din = 1'b0; max_clk = 1'b0; ce_ = 1'b1;
      model_reset();
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      check_regs();
      chk("reset_shutdown_n", shutdown_n, 1'b0);
      chk("reset_hex_valid", hex_valid, 8'h00);

      send_frame(32'h0C01, 16, 64, 0);
      send_frame(32'h0A07, 16, 64, 0);
      send_frame(32'h0B07, 16, 64, 0);
      chk("shutdown_on", shutdown_n, 1'b1);
      chk("intensity_7", intensity, 4'd7);
      chk("scan_limit_7", scan_limit, 3'd7);

      hx = 32'h89ABCDEF;
      for (int d = 1; d <= 8; d++)
         send_frame({20'h0, 4'(d), 1'b0, glyph[hx[4*(d-1) +: 4]]}, 16, 16, 0);
      chk("hex_89ABCDEF", hex_value, 32'h89ABCDEF);
      chk("hex_valid_FF", hex_valid, 8'hFF);
      send_frame(32'h0901, 16, 16, 0);
      chk("hex_valid_FE", hex_valid, 8'hFE);
      chk("hex_nib0_zero", hex_value[3:0], 4'h0);

      send_frame(32'h0312, 15, 16, 0);
      send_frame(32'h10477, 17, 16, 0);

      // Abort a frame with reset after 9 bits
      @(negedge clk) ce_ = 1'b0;
      repeat (8) @(negedge clk);
      for (int i = 0; i < 9; i++) begin
         max_din = 1'($urandom);
         repeat (8) @(negedge clk); max_clk = 1'b1;
         repeat (8) @(negedge clk); max_clk = 1'b0;
      end
      chk("sb_empty_before_reset", sb.size(), 0);
      rst_n = 1'b0; ce_ = 1'b1; max_clk = 1'b0; max_din = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      check_regs();
      send_frame(32'h0533, 16, 16, 0);
      chk("digit5_33", digits[39:32], 8'h33);
      chk("hex_nib4_4", hex_value[19:16], 4'h4);

      send_frame(32'h0C01, 16, 8, 1);
      send_frame(32'h0A5B, 16, 6, 1);

      for (int k = 0; k < 30; k++) begin
         a = 4'($urandom);
         bits = $urandom;
         bits[11:8] = a;
         if (a >= 4'd1 && a <= 4'd8 && $urandom_range(0, 1) == 1)
            bits[6:0] = glyph[$urandom_range(0, 15)];
         n = ($urandom_range(0, 4) == 0) ? $urandom_range(14, 18) : 16;
         send_frame(bits, n, $urandom_range(3, 9), 1'($urandom_range(0, 3) == 0));
      end

      repeat (20) @(negedge clk);
      chk("sb_drained", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
